// File: rtl/pclk_monitor.sv
// pclk_monitor: measures the period of an asynchronous slow clock in in_clk cycles and reports lock and loss.
// Optional PCLK_MON_DUTY_EN also measures the high time of each monitored period.
`timescale 1ns/1ps
module pclk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 10,
    parameter int TOLERANCE   = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [CNT_W-1:0] high_cycles
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOLERANCE);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   sync_last;
    logic                   rise_edge;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       prev;
    logic [CNT_W-1:0]       diff;
    logic [3:0]             match;
    logic                   in_tol;

    assign sync_last = sync[SYNC_STAGES-1];
    assign rise_edge = sync_last & ~sync_prev;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], mon_clk};
            sync_prev <= sync_last;
        end
    end

    // Cycle counter since the last rising edge; saturates so a dead clock reads as TIMEOUT
    always_ff @(posedge in_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise_edge) begin
            cnt <= ONE_C;
        end else if (cnt < TIMEOUT_C) begin
            cnt <= cnt + ONE_C;
        end
    end

    assign diff   = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
    assign in_tol = (diff <= TOL_C);

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
            prev         <= '0;
            match        <= '0;
        end else begin
            period_valid <= 1'b0;
            if (rise_edge) begin
                lost <= 1'b0;
                case (state)
                    IDLE: begin
                        state <= MEASURE;
                    end
                    MEASURE: begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        prev         <= cnt;
                        match        <= '0;
                        state        <= TRACK;
                    end
                    default: begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        prev         <= cnt;
                        if (in_tol) begin
                            if (match < LOCK_C) match <= match + 4'd1;
                            if (match >= LOCK_C - 4'd1) locked <= 1'b1;
                        end else begin
                            match  <= '0;
                            locked <= 1'b0;
                        end
                    end
                endcase
            end else if (cnt == TIMEOUT_C) begin
                lost   <= 1'b1;
                locked <= 1'b0;
                match  <= '0;
                state  <= IDLE;
            end
        end
    end

`ifdef PCLK_MON_DUTY_EN
    logic             fall_edge;
    logic             high_run;
    logic [CNT_W-1:0] high_cnt;

    assign fall_edge = ~sync_last & sync_prev;

    // High-time counter runs from the rising edge and freezes at the falling edge
    always_ff @(posedge in_clk) begin
        if (reset) begin
            high_cnt    <= '0;
            high_run    <= 1'b0;
            high_cycles <= '0;
        end else begin
            if (rise_edge) begin
                high_cnt <= ONE_C;
                high_run <= 1'b1;
            end else if (fall_edge) begin
                high_run <= 1'b0;
            end else if (high_run && (high_cnt < TIMEOUT_C)) begin
                high_cnt <= high_cnt + ONE_C;
            end
            if (rise_edge && (state != IDLE)) high_cycles <= high_cnt;
        end
    end
`else
    assign high_cycles = '0;
`endif

endmodule

// File: tb/tb_pclk_monitor.sv
// Directed self-checking bench for pclk_monitor: lock, tolerance, loss, reset, edge/timeout race, async sampling.
`timescale 1ns/1ps
module tb_pclk_monitor;

`ifdef PCLK_MON_DUTY_EN
    localparam int EXP_HIGH6  = 3;
    localparam int EXP_HIGH20 = 10;
`else
    localparam int EXP_HIGH6  = 0;
    localparam int EXP_HIGH20 = 0;
`endif

    logic       in_clk;
    logic       reset;
    logic       mon_clk;
    logic       mon_clk2;
    logic [9:0] period, period2;
    logic       period_valid, period_valid2;
    logic       locked, locked2;
    logic       lost, lost2;
    logic [9:0] high_cycles, high_cycles2;

    int vectors     = 0;
    int miscompares = 0;

    pclk_monitor dut (
        .in_clk(in_clk), .reset(reset), .mon_clk(mon_clk),
        .period(period), .period_valid(period_valid), .locked(locked),
        .lost(lost), .high_cycles(high_cycles)
    );

    pclk_monitor #(.TIMEOUT(20)) dut_race (
        .in_clk(in_clk), .reset(reset), .mon_clk(mon_clk2),
        .period(period2), .period_valid(period_valid2), .locked(locked2),
        .lost(lost2), .high_cycles(high_cycles2)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Observer of period_valid pulses; sole writer of these statistics
    int   pv_cnt      = 0;
    int   pv2_cnt     = 0;
    int   lock_at     = 0;
    int   double_pv   = 0;
    int   async_pv    = 0;
    int   async_bad   = 0;
    logic locked_at_9;
    logic prev_pv     = 1'b0;
    logic prev_lock   = 1'b0;
    logic async_phase = 1'b0;

    always @(posedge in_clk) begin
        #1;
        if (period_valid) begin
            pv_cnt++;
            if (locked && !prev_lock) lock_at = pv_cnt;
            if (period == 10'd9) locked_at_9 = locked;
            if (prev_pv) double_pv++;
            if (async_phase) begin
                async_pv++;
                if (period < 10'd6 || period > 10'd7) async_bad++;
            end
        end
        if (period_valid2) pv2_cnt++;
        prev_pv   = period_valid;
        prev_lock = locked;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    // Drives n periods of hi/lo in_clk cycles on the selected monitored clock; caller sits on a negedge
    task automatic applyStimulus(input int sel, input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 2) mon_clk2 = 1'b1; else mon_clk = 1'b1;
            repeat (hi) @(negedge in_clk);
            if (sel == 2) mon_clk2 = 1'b0; else mon_clk = 1'b0;
            repeat (lo) @(negedge in_clk);
        end
    endtask

    task automatic pulseReset(input int n);
        reset = 1'b1;
        waitCycles(n);
        reset = 1'b0;
    endtask

    int base;
    int phase;

    initial begin
        reset    = 1'b1;
        mon_clk  = 1'b0;
        mon_clk2 = 1'b0;
        waitCycles(3);
        checkOutput("reset_period", period, 0);
        checkOutput("reset_valid", period_valid, 0);
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_lost", lost, 0);
        checkOutput("reset_high", high_cycles, 0);
        reset = 1'b0;

        $display("[TB] nominal lock, period 6");
        base = pv_cnt;
        applyStimulus(1, 3, 3, 2);
        checkOutput("nom_first_pv_count", pv_cnt - base, 1);
        checkOutput("nom_first_period", period, 6);
        checkOutput("nom_not_locked_yet", locked, 0);
        applyStimulus(1, 3, 3, 4);
        checkOutput("nom_pv_count", pv_cnt - base, 5);
        checkOutput("nom_locked", locked, 1);
        checkOutput("nom_lock_index", lock_at - base, 5);
        checkOutput("nom_high_cycles", high_cycles, EXP_HIGH6);

        $display("[TB] tolerance, alternating 6/7 then 9");
        pulseReset(2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 3, 3, 1);
            applyStimulus(1, 3, 4, 1);
        end
        checkOutput("tol_locked_6_7", locked, 1);
        applyStimulus(1, 4, 5, 1);
        applyStimulus(1, 3, 3, 5);
        checkOutput("tol_locked_at_9", locked_at_9, 0);
        checkOutput("tol_relock_pending", locked, 0);
        applyStimulus(1, 3, 3, 1);
        checkOutput("tol_relocked", locked, 1);

        $display("[TB] loss of monitored clock");
        waitCycles(1015);
        checkOutput("loss_not_yet", lost, 0);
        waitCycles(10);
        checkOutput("loss_lost", lost, 1);
        checkOutput("loss_unlocked", locked, 0);
        checkOutput("loss_period_kept", period, 6);
        base = pv_cnt;
        applyStimulus(1, 3, 3, 1);
        checkOutput("loss_cleared", lost, 0);
        checkOutput("loss_no_pv_first_edge", pv_cnt - base, 0);
        applyStimulus(1, 3, 3, 1);
        checkOutput("loss_pv_second_edge", pv_cnt - base, 1);
        checkOutput("loss_restart_period", period, 6);
        applyStimulus(1, 3, 3, 5);
        checkOutput("loss_relocked", locked, 1);

        $display("[TB] reset while locked");
        pulseReset(1);
        checkOutput("rst_period", period, 0);
        checkOutput("rst_valid", period_valid, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_lost", lost, 0);
        checkOutput("rst_high", high_cycles, 0);
        applyStimulus(1, 3, 3, 5);
        checkOutput("rst_relock_pending", locked, 0);
        applyStimulus(1, 3, 3, 1);
        checkOutput("rst_relocked", locked, 1);

        $display("[TB] edge/timeout race with TIMEOUT=20");
        checkOutput("race_idle_lost", lost2, 1);
        base = pv2_cnt;
        applyStimulus(2, 10, 10, 6);
        checkOutput("race_lost", lost2, 0);
        checkOutput("race_period", period2, 20);
        checkOutput("race_pv_count", pv2_cnt - base, 5);
        checkOutput("race_locked", locked2, 1);
        checkOutput("race_high", high_cycles2, EXP_HIGH20);

        $display("[TB] asynchronous 6.5-cycle monitored clock");
        pulseReset(2);
        async_phase = 1'b1;
        phase = $urandom_range(0, 64);
        #(phase);
        repeat (80) #32.5 mon_clk = ~mon_clk;
        mon_clk = 1'b0;
        @(negedge in_clk);
        waitCycles(4);
        async_phase = 1'b0;
        checkOutput("async_locked", locked, 1);
        checkOutput("async_bad_periods", async_bad, 0);
        checkOutput("async_enough_pv", async_pv >= 35, 1);
        checkOutput("double_pv_pulses", double_pv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
